fifo_i2c: RTL

FIFO_I2C -- requirements
Module: fifo_i2c

---
 rtl/fifo_i2c_if.sv | 26 ++
 rtl/fifo_i2c.sv | 99 +++++++++
 2 files changed

// File: rtl/fifo_i2c_if.sv
// Bus bundle for fifo_i2c: push/pop handshake, head data, occupancy and error status.
interface fifo_i2c_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 5
);
    logic              WR_ENA;
    logic [DWIDTH-1:0] DATA_IN;
    logic              RD_ENA;
    logic [DWIDTH-1:0] DATA_OUT;
    logic              FULL;
    logic              EMPTY;
    logic [AWIDTH:0]   COUNT;
    logic              ERR_CLR;
    logic              OVERFLOW;
    logic              UNDERFLOW;

    modport master (
        output WR_ENA, DATA_IN, RD_ENA, ERR_CLR,
        input  DATA_OUT, FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WR_ENA, DATA_IN, RD_ENA, ERR_CLR,
        output DATA_OUT, FULL, EMPTY, COUNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/fifo_i2c.sv
// First-word-fall-through synchronous FIFO, 2^AWIDTH x DWIDTH, count-based full/empty.
// Define FIFO_I2C_ERR_FLAGS_EN to enable sticky OVERFLOW/UNDERFLOW flags.
module fifo_i2c #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 5
) (
    input logic          PCLK,
    input logic          PRESET,
    fifo_i2c_if.slave    bus
);
    localparam int unsigned Depth = 2 ** AWIDTH;

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic [DWIDTH-1:0] mem_q [Depth];

    logic full, empty, push_ok, pop_ok;

    always_comb begin
        full    = (count_q == (AWIDTH + 1)'(Depth));
        empty   = (count_q == '0);
        // A full FIFO still takes a push when a pop frees the head slot on the same edge.
        push_ok = bus.WR_ENA && (!full || bus.RD_ENA);
        pop_ok  = bus.RD_ENA && !empty;

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; zeroed pointers and count make stale words unreachable.
    always_ff @(posedge PCLK) begin
        if (!PRESET && push_ok) begin
            mem_q[wr_ptr_q] <= bus.DATA_IN;
        end
    end

    always_comb begin
        bus.DATA_OUT = empty ? '0 : mem_q[rd_ptr_q];
        bus.FULL     = full;
        bus.EMPTY    = empty;
        bus.COUNT    = count_q;
    end

`ifdef FIFO_I2C_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A set event wins over a coincident clear.
    always_comb begin
        ovf_d = bus.ERR_CLR ? 1'b0 : ovf_q;
        udf_d = bus.ERR_CLR ? 1'b0 : udf_q;
        if (bus.WR_ENA && full && !bus.RD_ENA) ovf_d = 1'b1;
        if (bus.RD_ENA && empty) udf_d = 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    always_comb begin
        bus.OVERFLOW  = ovf_q;
        bus.UNDERFLOW = udf_q;
    end
`else
    logic unused_err_clr;

    always_comb begin
        unused_err_clr = bus.ERR_CLR;
        bus.OVERFLOW   = 1'b0;
        bus.UNDERFLOW  = 1'b0;
    end
`endif
endmodule
